// File: rtl/hashmap_exerciser.sv
// Burst traffic generator and result checker for the hashmap insert/lookup port.
// One start edge issues `count` ops over an arithmetic key sequence and gathers hit/miss/stall statistics.
module hashmap_exerciser #(
   parameter int KEY_BITS   = 64,
   parameter int VAL_BITS   = 64,
   parameter int CNT_BITS   = 16,
   parameter int LOOKUP_LAT = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [KEY_BITS-1:0] base_key,
   input  logic [KEY_BITS-1:0] stride,
   input  logic [VAL_BITS-1:0] base_val,
   input  logic [CNT_BITS-1:0] count,
   output logic                insert,
   output logic [KEY_BITS-1:0] ins_key,
   output logic [VAL_BITS-1:0] ins_value,
   input  logic                busy,
   output logic                lookup,
   output logic [KEY_BITS-1:0] key,
   output logic                modify,
   output logic                del,
   output logic [VAL_BITS-1:0] mod_value,
   input  logic                valid,
   input  logic [VAL_BITS-1:0] value,
   output logic                running,
   output logic                done,
   output logic [CNT_BITS-1:0] issued,
   output logic [CNT_BITS-1:0] hits,
   output logic [CNT_BITS-1:0] misses,
   output logic [CNT_BITS-1:0] stalls,
   output logic [VAL_BITS-1:0] value_xor
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [1:0] MODE_INSERT = 2'd0;
   localparam logic [1:0] MODE_MODIFY = 2'd2;
   localparam logic [1:0] MODE_DELETE = 2'd3;

   state_t                state_q, state_d;
   logic                  start_dly_q, start_dly_d;
   logic                  arm_q, arm_d;
   logic [1:0]            mode_q, mode_d;
   logic [KEY_BITS-1:0]   stride_q, stride_d;
   logic [CNT_BITS-1:0]   count_q, count_d;
   logic [CNT_BITS-1:0]   idx_q, idx_d;
   logic [KEY_BITS-1:0]   cur_key_q, cur_key_d;
   logic [VAL_BITS-1:0]   cur_val_q, cur_val_d;
   logic                  insert_q, insert_d;
   logic [KEY_BITS-1:0]   ins_key_q, ins_key_d;
   logic [VAL_BITS-1:0]   ins_value_q, ins_value_d;
   logic                  lookup_q, lookup_d;
   logic [KEY_BITS-1:0]   key_q, key_d;
   logic                  modify_q, modify_d;
   logic                  del_q, del_d;
   logic [VAL_BITS-1:0]   mod_value_q, mod_value_d;
   logic [LOOKUP_LAT-1:0] flags_q, flags_d;
   logic                  running_q, running_d;
   logic                  done_q, done_d;
   logic [CNT_BITS-1:0]   issued_q, issued_d;
   logic [CNT_BITS-1:0]   hits_q, hits_d;
   logic [CNT_BITS-1:0]   misses_q, misses_d;
   logic [CNT_BITS-1:0]   stalls_q, stalls_d;
   logic [VAL_BITS-1:0]   value_xor_q, value_xor_d;

   logic                  launch;
   logic                  ops_left;
   logic                  do_issue;
   logic [1:0]            op_mode;
   logic [KEY_BITS-1:0]   op_key;
   logic [KEY_BITS-1:0]   op_stride;
   logic [VAL_BITS-1:0]   op_val;
   logic [CNT_BITS-1:0]   op_idx;

   always_comb begin
      // NOTE: every variable gets its default first, so no path through this block can infer a latch.
      state_d     = state_q;
      start_dly_d = start;
      arm_d       = arm_q | ~start;
      mode_d      = mode_q;
      stride_d    = stride_q;
      count_d     = count_q;
      idx_d       = idx_q;
      cur_key_d   = cur_key_q;
      cur_val_d   = cur_val_q;
      insert_d    = 1'b0;
      ins_key_d   = ins_key_q;
      ins_value_d = ins_value_q;
      lookup_d    = 1'b0;
      key_d       = key_q;
      modify_d    = 1'b0;
      del_d       = 1'b0;
      mod_value_d = mod_value_q;
      issued_d    = issued_q;
      hits_d      = hits_q;
      misses_d    = misses_q;
      stalls_d    = stalls_q;
      value_xor_d = value_xor_q;
      do_issue    = 1'b0;

      // The arm flag keeps a start held high through reset from launching until it is seen low.
      launch    = start & ~start_dly_q & arm_q & ((state_q == IDLE) | (state_q == DONE));
      op_mode   = launch ? mode     : mode_q;
      op_key    = launch ? base_key : cur_key_q;
      op_stride = launch ? stride   : stride_q;
      op_val    = launch ? base_val : cur_val_q;
      op_idx    = launch ? '0       : idx_q;
      ops_left  = launch ? (count != '0) : ((state_q == RUN) && (idx_q != count_q));

      // The top flag marks the cycle whose valid/value belongs to an issued lookup.
      flags_d = (flags_q << 1) | LOOKUP_LAT'(lookup_q);
      if (flags_q[LOOKUP_LAT-1]) begin
         if (valid) begin
            hits_d      = hits_q + CNT_BITS'(1);
            value_xor_d = value_xor_q ^ value;
         end else begin
            misses_d = misses_q + CNT_BITS'(1);
         end
      end
      if (insert_q | lookup_q) issued_d = issued_q + CNT_BITS'(1);

      case (state_q)
         IDLE, DONE: begin
            if (launch) begin
               mode_d      = mode;
               stride_d    = stride;
               count_d     = count;
               idx_d       = '0;
               cur_key_d   = base_key;
               cur_val_d   = base_val;
               issued_d    = '0;
               hits_d      = '0;
               misses_d    = '0;
               stalls_d    = '0;
               value_xor_d = '0;
               state_d     = (count == '0) ? DONE : RUN;
            end
         end
         RUN:     if (idx_q == count_q) state_d = DRAIN;
         DRAIN:   if ((mode_q == MODE_INSERT) ? ~busy : (flags_d == '0)) state_d = DONE;
         default: state_d = IDLE;
      endcase

      if (ops_left) begin
         if (op_mode == MODE_INSERT) begin
            if (!busy && !insert_q) begin
               do_issue = 1'b1;
            end else if (busy && (state_q == RUN) && (stalls_q != '1)) begin
               stalls_d = stalls_q + CNT_BITS'(1);
            end
         end else begin
            do_issue = 1'b1;
         end
      end

      if (do_issue) begin
         idx_d     = op_idx + CNT_BITS'(1);
         cur_key_d = op_key + op_stride;
         cur_val_d = op_val + VAL_BITS'(1);
         if (op_mode == MODE_INSERT) begin
            insert_d    = 1'b1;
            ins_key_d   = op_key;
            ins_value_d = op_val;
         end else begin
            lookup_d = 1'b1;
            key_d    = op_key;
            modify_d = (op_mode == MODE_MODIFY);
            del_d    = (op_mode == MODE_DELETE);
            if (op_mode == MODE_MODIFY) mod_value_d = op_val;
         end
      end

      running_d = (state_d == RUN) | (state_d == DRAIN);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         start_dly_q <= 1'b0;
         arm_q       <= 1'b0;
         mode_q      <= '0;
         stride_q    <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         cur_key_q   <= '0;
         cur_val_q   <= '0;
         insert_q    <= 1'b0;
         ins_key_q   <= '0;
         ins_value_q <= '0;
         lookup_q    <= 1'b0;
         key_q       <= '0;
         modify_q    <= 1'b0;
         del_q       <= 1'b0;
         mod_value_q <= '0;
         // NOTE: the issue-flag shift register is reset too, so results in flight at reset are never counted.
         flags_q     <= '0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         issued_q    <= '0;
         hits_q      <= '0;
         misses_q    <= '0;
         stalls_q    <= '0;
         value_xor_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other.
         state_q     <= state_d;
         start_dly_q <= start_dly_d;
         arm_q       <= arm_d;
         mode_q      <= mode_d;
         stride_q    <= stride_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         cur_key_q   <= cur_key_d;
         cur_val_q   <= cur_val_d;
         insert_q    <= insert_d;
         ins_key_q   <= ins_key_d;
         ins_value_q <= ins_value_d;
         lookup_q    <= lookup_d;
         key_q       <= key_d;
         modify_q    <= modify_d;
         del_q       <= del_d;
         mod_value_q <= mod_value_d;
         flags_q     <= flags_d;
         running_q   <= running_d;
         done_q      <= done_d;
         issued_q    <= issued_d;
         hits_q      <= hits_d;
         misses_q    <= misses_d;
         stalls_q    <= stalls_d;
         value_xor_q <= value_xor_d;
      end
   end

   assign insert    = insert_q;
   assign ins_key   = ins_key_q;
   assign ins_value = ins_value_q;
   assign lookup    = lookup_q;
   assign key       = key_q;
   assign modify    = modify_q;
   assign del       = del_q;
   assign mod_value = mod_value_q;
   assign running   = running_q;
   assign done      = done_q;
   assign issued    = issued_q;
   assign hits      = hits_q;
   assign misses    = misses_q;
   assign stalls    = stalls_q;
   assign value_xor = value_xor_q;

endmodule

// File: tb/tb_hashmap_exerciser.sv
// Scoreboard bench for hashmap_exerciser: directed bursts push expected strobes and end-of-burst
// statistics; a monitor pops and compares them as the DUT presents strobes and done.
module tb_hashmap_exerciser;

   localparam int LAT = 6;

   logic        clk = 1'b0;
   logic        rst_n, start, busy, valid;
   logic [1:0]  mode;
   logic [63:0] base_key, stride, base_val, value;
   logic [15:0] count;
   logic        insert, lookup, modify, del, running, done;
   logic [63:0] ins_key, ins_value, key, mod_value, value_xor;
   logic [15:0] issued, hits, misses, stalls;

   hashmap_exerciser #(
      .KEY_BITS(64), .VAL_BITS(64), .CNT_BITS(16), .LOOKUP_LAT(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_key(base_key),
      .stride(stride), .base_val(base_val), .count(count),
      .insert(insert), .ins_key(ins_key), .ins_value(ins_value), .busy(busy),
      .lookup(lookup), .key(key), .modify(modify), .del(del), .mod_value(mod_value),
      .valid(valid), .value(value), .running(running), .done(done),
      .issued(issued), .hits(hits), .misses(misses), .stalls(stalls), .value_xor(value_xor)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   initial forever @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      bit          is_done;
      int          cyc;
      bit          is_ins;
      logic [63:0] key;
      logic [63:0] val;
      bit          chk_val;
      bit          mdf;
      bit          dl;
      logic [15:0] issued;
      logic [15:0] hits;
      logic [15:0] misses;
      logic [15:0] stalls;
      logic [63:0] vx;
   } exp_t;

   exp_t sb[$];

   task automatic push_op(input int c, input bit ins, input logic [63:0] k, input logic [63:0] v,
                          input bit chk_val, input bit mdf, input bit dl);
      exp_t e;
      e.is_done = 1'b0; e.cyc = c; e.is_ins = ins; e.key = k; e.val = v; e.chk_val = chk_val;
      e.mdf = mdf; e.dl = dl; e.issued = '0; e.hits = '0; e.misses = '0; e.stalls = '0; e.vx = '0;
      sb.push_back(e);
   endtask

   task automatic push_done(input int c, input logic [15:0] n_iss, input logic [15:0] n_hit,
                            input logic [15:0] n_miss, input logic [15:0] n_stall, input logic [63:0] vx);
      exp_t e;
      e.is_done = 1'b1; e.cyc = c; e.is_ins = 1'b0; e.key = '0; e.val = '0; e.chk_val = 1'b0;
      e.mdf = 1'b0; e.dl = 1'b0; e.issued = n_iss; e.hits = n_hit; e.misses = n_miss;
      e.stalls = n_stall; e.vx = vx;
      sb.push_back(e);
   endtask

   // Hashmap stand-in: keys 0x10 and 0x12 are present; results appear LAT cycles after lookup.
   // Cycles with no result due drive valid=1 with junk data, which the DUT must ignore.
   typedef struct packed {
      logic        flag;
      logic        hit;
      logic [63:0] val;
   } rsp_t;
   rsp_t pipe [0:LAT];

   initial begin
      for (int i = 0; i <= LAT; i++) pipe[i] = '0;
      valid = 1'b0;
      value = '0;
      forever begin
         @(negedge clk);
         for (int k = LAT; k > 0; k--) pipe[k] = pipe[k-1];
         pipe[0].flag = lookup;
         pipe[0].hit  = lookup && ((key == 64'h10) || (key == 64'h12));
         pipe[0].val  = (key == 64'h10) ? 64'hA : 64'h5;
         if (pipe[LAT].flag) begin
            valid = pipe[LAT].hit;
            value = pipe[LAT].hit ? pipe[LAT].val : 64'hDEAD_0000;
         end else begin
            valid = 1'b1;
            value = 64'hBAD0_BAD0_BAD0_BAD0;
         end
      end
   end

   // Monitor: pops one expectation per strobe cycle and per rising edge of done.
   initial begin
      exp_t e;
      logic done_prev;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (insert || lookup) begin
            if (sb.size() == 0 || sb[0].is_done) begin
               check("unexpected_strobe", {62'd0, insert, lookup}, 64'd0);
            end else begin
               e = sb.pop_front();
               check("strobe_cycle", 64'(cyc), 64'(e.cyc));
               check("strobe_running", {63'd0, running}, 64'd1);
               check("insert", {63'd0, insert}, {63'd0, e.is_ins});
               check("lookup", {63'd0, lookup}, {63'd0, !e.is_ins});
               check("modify", {63'd0, modify}, {63'd0, e.mdf});
               check("del", {63'd0, del}, {63'd0, e.dl});
               if (e.is_ins) begin
                  check("ins_key", ins_key, e.key);
                  check("ins_value", ins_value, e.val);
               end else begin
                  check("key", key, e.key);
                  if (e.chk_val) check("mod_value", mod_value, e.val);
               end
            end
         end else begin
            check("idle_mode_flags", {62'd0, modify, del}, 64'd0);
         end
         if (done && !done_prev) begin
            if (sb.size() == 0 || !sb[0].is_done) begin
               check("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
               e = sb.pop_front();
               check("done_cycle", 64'(cyc), 64'(e.cyc));
               check("done_running", {63'd0, running}, 64'd0);
               check("issued", 64'(issued), 64'(e.issued));
               check("hits", 64'(hits), 64'(e.hits));
               check("misses", 64'(misses), 64'(e.misses));
               check("stalls", 64'(stalls), 64'(e.stalls));
               check("value_xor", value_xor, e.vx);
            end
         end
         done_prev = done;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic launch(input logic [1:0] m, input logic [63:0] bk, input logic [63:0] st,
                         input logic [63:0] bv, input logic [15:0] n, output int t);
      @(negedge clk);
      mode = m; base_key = bk; stride = st; base_val = bv; count = n;
      start = 1'b1;
      t = cyc;
   endtask

   // Drops start one cycle after launch and scrambles the burst inputs, which must be ignored.
   task automatic release_start();
      @(negedge clk);
      start    = 1'b0;
      mode     = ~mode;
      base_key = 64'hA5A5_A5A5_A5A5_A5A5;
      stride   = 64'h3;
      base_val = 64'h5A5A;
      count    = 16'd9;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && !done; i++) @(negedge clk);
      check("done_within_budget", {63'd0, done}, 64'd1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_strobes"}, {58'd0, insert, lookup, modify, del, running, done}, 64'd0);
      check({tag, "_ins_key"}, ins_key, 64'd0);
      check({tag, "_ins_value"}, ins_value, 64'd0);
      check({tag, "_key"}, key, 64'd0);
      check({tag, "_mod_value"}, mod_value, 64'd0);
      check({tag, "_counters"}, {issued, hits, misses, stalls}, 64'd0);
      check({tag, "_value_xor"}, value_xor, 64'd0);
   endtask

   initial begin
      int t;
      rst_n = 1'b0; start = 1'b0; busy = 1'b0; mode = '0;
      base_key = '0; stride = '0; base_val = '0; count = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("reset");

      // Lookup burst with two model hits; start toggled during RUN must not relaunch.
      launch(2'd1, 64'h10, 64'h1, 64'h100, 16'd4, t);
      for (int i = 0; i < 4; i++) push_op(t + 1 + i, 1'b0, 64'h10 + 64'(i), 64'h0, 1'b0, 1'b0, 1'b0);
      push_done(t + 4 + LAT + 1, 16'd4, 16'd2, 16'd2, 16'd0, 64'hF);
      release_start();
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(40);

      // Insert burst with busy high for cycles T+2..T+5.
      launch(2'd0, 64'h1000, 64'h10, 64'h77, 16'd3, t);
      push_op(t + 1, 1'b1, 64'h1000, 64'h77, 1'b1, 1'b0, 1'b0);
      push_op(t + 7, 1'b1, 64'h1010, 64'h78, 1'b1, 1'b0, 1'b0);
      push_op(t + 9, 1'b1, 64'h1020, 64'h79, 1'b1, 1'b0, 1'b0);
      push_done(t + 11, 16'd3, 16'd0, 16'd0, 16'd4, 64'h0);
      release_start();
      @(negedge clk);
      busy = 1'b1;
      repeat (4) @(negedge clk);
      busy = 1'b0;
      wait_done(40);

      // Modify burst with key and value wrap-around.
      launch(2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2, t);
      push_op(t + 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
      push_op(t + 2, 1'b0, 64'h1, 64'h0, 1'b1, 1'b1, 1'b0);
      push_done(t + 2 + LAT + 1, 16'd2, 16'd0, 16'd2, 16'd0, 64'h0);
      release_start();
      wait_done(40);

      // Delete burst: one hit among three keys.
      launch(2'd3, 64'h11, 64'h1, 64'h50, 16'd3, t);
      for (int i = 0; i < 3; i++) push_op(t + 1 + i, 1'b0, 64'h11 + 64'(i), 64'h0, 1'b0, 1'b0, 1'b1);
      push_done(t + 3 + LAT + 1, 16'd3, 16'd1, 16'd2, 16'd0, 64'h5);
      release_start();
      wait_done(40);

      // count=0: straight to DONE with cleared statistics and held key.
      launch(2'd1, 64'h10, 64'h1, 64'h0, 16'd0, t);
      release_start();
      check("cnt0_done", {63'd0, done}, 64'd1);
      check("cnt0_running", {63'd0, running}, 64'd0);
      check("cnt0_counters", {issued, hits, misses, stalls}, 64'd0);
      check("cnt0_value_xor", value_xor, 64'd0);
      check("cnt0_key_held", key, 64'h13);
      repeat (3) @(negedge clk);
      check("cnt0_done_sticky", {63'd0, done}, 64'd1);

      // Reset in DRAIN with start held high through and after reset.
      launch(2'd1, 64'h10, 64'h2, 64'h0, 16'd2, t);
      push_op(t + 1, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0, 1'b0);
      push_op(t + 2, 1'b0, 64'h12, 64'h0, 1'b0, 1'b0, 1'b0);
      release_start();
      repeat (3) @(negedge clk);
      check("drain_running", {62'd0, running, done}, 64'd2);
      rst_n = 1'b0;
      start = 1'b1;
      @(negedge clk);
      check_zero("drain_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("held_start_no_launch", {62'd0, running, done}, 64'd0);
      check("held_start_counters", {issued, hits, misses, stalls}, 64'd0);
      start = 1'b0;
      @(negedge clk);

      launch(2'd1, 64'h12, 64'h0, 64'h0, 16'd1, t);
      push_op(t + 1, 1'b0, 64'h12, 64'h0, 1'b0, 1'b0, 1'b0);
      push_done(t + 1 + LAT + 1, 16'd1, 16'd1, 16'd0, 16'd0, 64'h5);
      release_start();
      wait_done(40);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
